// File: rtl/fpu_pkg.sv
// Shared FPU issue/writeback types: unit class encoding, default latencies, reservation tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  // Unit class, also the bit index into the one-hot start vector.
  typedef enum logic [1:0] {
    CLS_CMP = 2'd0,
    CLS_ADD = 2'd1,
    CLS_MUL = 2'd2,
    CLS_DIV = 2'd3
  } fpu_cls_e;

  // Default unit latencies, cycles from start to result valid.
  localparam int FPU_LAT_CMP = 1;
  localparam int FPU_LAT_MUL = 2;
  localparam int FPU_LAT_ADD = 3;
  localparam int FPU_LAT_DIV = 6;

  // Reservation depth; every unit latency must fit in 1..FPU_MAXLAT-1.
  localparam int FPU_MAXLAT = 8;

  // Architectural register index width carried in the tag.
  localparam int FPU_RD_W = 5;

  // Tag travelling with each reserved writeback slot.
  typedef struct packed {
    fpu_cls_e              cls;
    logic [FPU_RD_W-1:0]   rd;
  } fpu_tag_t;

endpackage

// File: rtl/fpu_wb_slot_ring.sv
// Writeback reservation ring: MAXLAT-deep shift register of {valid, tag}, entry k = result k cycles out.
// Latency: a load at index i reaches entry 0 after i further shifts; clear takes effect on the next edge.
// Backpressure: none internally; the caller must only load an index it knows will be empty.
// Ports: clk/rstn clock and async active-low reset; clr empties the ring; ld_en/ld_idx/ld_tag place a
//        reservation; slot exposes all valid bits; tag0 is the tag of the entry arriving this cycle.
module fpu_wb_slot_ring
  import fpu_pkg::*;
#(
  parameter int MAXLAT = FPU_MAXLAT,
  parameter int IDX_W  = $clog2(MAXLAT)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  fpu_tag_t          ld_tag,
  output logic [MAXLAT-1:0] slot,
  output fpu_tag_t          tag0
);

  logic [MAXLAT-1:0] slot_q;
  fpu_tag_t          tag_q [MAXLAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q <= '0;
      for (int k = 0; k < MAXLAT; k++) begin
        tag_q[k] <= '0;
      end
    end else if (clr) begin
      slot_q <= '0;
      for (int k = 0; k < MAXLAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      // Advance every reservation one cycle closer to arrival.
      for (int k = 0; k < MAXLAT - 1; k++) begin
        slot_q[k] <= slot_q[k+1];
        tag_q[k]  <= tag_q[k+1];
      end
      slot_q[MAXLAT-1] <= 1'b0;
      tag_q[MAXLAT-1]  <= '0;
      // The load overrides the shifted-in value; the issue check guarantees that value was empty.
      if (ld_en) begin
        slot_q[ld_idx] <= 1'b1;
        tag_q[ld_idx]  <= ld_tag;
      end
    end
  end

  assign slot = slot_q;
  assign tag0 = tag_q[0];

endmodule

// File: rtl/fpu_wb_scheduler.sv
// FPU issue and writeback scheduler: issues one op per cycle, reserves the shared writeback slot, muxes results.
// Latency: op accepted in cycle t writes back (registered) in cycle t+L+1, L = latency of its unit class.
// Backpressure: in_ready drops when the op's arrival slot is already taken or during flush; younger op stalls.
// Ports: clk/rstn clock and async active-low reset; in_valid/in_ready/in_cls/in_rd decode handshake;
//        flush drops all in-flight reservations; start one-hot unit start; res_* unit results;
//        wb_valid/wb_rd/wb_to_int/wb_data registered register-file writeback.
module fpu_wb_scheduler
  import fpu_pkg::*;
#(
  parameter int LAT_CMP = FPU_LAT_CMP,
  parameter int LAT_MUL = FPU_LAT_MUL,
  parameter int LAT_ADD = FPU_LAT_ADD,
  parameter int LAT_DIV = FPU_LAT_DIV,
  parameter int MAXLAT  = FPU_MAXLAT,
  parameter int RD_W    = FPU_RD_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_cls,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,
  output logic [3:0]      start,
  input  logic [31:0]     res_cmp,
  input  logic [31:0]     res_add,
  input  logic [31:0]     res_mul,
  input  logic [31:0]     res_div,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_to_int,
  output logic [31:0]     wb_data
);

  localparam int IDX_W = $clog2(MAXLAT);

  // Latencies must leave room for the ready check at index L, which must exist in the ring.
  // The tag struct is shared, so the register index width is fixed by the package.
  if (LAT_CMP < 1 || LAT_CMP > MAXLAT - 1 ||
      LAT_MUL < 1 || LAT_MUL > MAXLAT - 1 ||
      LAT_ADD < 1 || LAT_ADD > MAXLAT - 1 ||
      LAT_DIV < 1 || LAT_DIV > MAXLAT - 1) begin : g_bad_lat
    $error("fpu_wb_scheduler: every unit latency must be in 1..MAXLAT-1");
  end
  if (RD_W != FPU_RD_W) begin : g_bad_rd_w
    $error("fpu_wb_scheduler: RD_W must match fpu_pkg::FPU_RD_W");
  end

  logic [MAXLAT-1:0] slot;
  fpu_tag_t          tag0;
  fpu_tag_t          ld_tag;
  logic [IDX_W-1:0]  sel_lat;
  logic [IDX_W-1:0]  ld_idx;
  logic              fire;
  logic [31:0]       res_sel;

  // Latency of the offered op's unit.
  always_comb begin
    sel_lat = IDX_W'(LAT_CMP);
    case (in_cls)
      CLS_CMP: sel_lat = IDX_W'(LAT_CMP);
      CLS_ADD: sel_lat = IDX_W'(LAT_ADD);
      CLS_MUL: sel_lat = IDX_W'(LAT_MUL);
      CLS_DIV: sel_lat = IDX_W'(LAT_DIV);
      default: sel_lat = IDX_W'(LAT_CMP);
    endcase
  end

  // slot[L] shifts into L-1 on the same edge the new op would load there, so it is the one to check.
  assign in_ready = !slot[sel_lat] && !flush;
  assign fire     = in_valid && in_ready;
  assign ld_idx   = sel_lat - IDX_W'(1);

  always_comb begin
    ld_tag     = '0;
    ld_tag.cls = fpu_cls_e'(in_cls);
    ld_tag.rd  = in_rd;
  end

  always_comb begin
    start         = '0;
    start[in_cls] = fire;
  end

  fpu_wb_slot_ring #(
    .MAXLAT (MAXLAT),
    .IDX_W  (IDX_W)
  ) u_ring (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (flush),
    .ld_en  (fire),
    .ld_idx (ld_idx),
    .ld_tag (ld_tag),
    .slot   (slot),
    .tag0   (tag0)
  );

  // Pick the result of the unit whose reservation arrives this cycle.
  always_comb begin
    res_sel = res_cmp;
    case (tag0.cls)
      CLS_CMP: res_sel = res_cmp;
      CLS_ADD: res_sel = res_add;
      CLS_MUL: res_sel = res_mul;
      CLS_DIV: res_sel = res_div;
      default: res_sel = res_cmp;
    endcase
  end

  // Payload fields hold between writebacks; only wb_valid is cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_to_int <= 1'b0;
      wb_data   <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (slot[0]) begin
      wb_valid  <= 1'b1;
      wb_rd     <= tag0.rd;
      wb_to_int <= (tag0.cls == CLS_CMP);
      wb_data   <= res_sel;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// Directed bench for fpu_wb_scheduler: issue, collision stall, back-to-back, flush, reset, mixed stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_fpu_wb_scheduler;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cls;
  logic [4:0]  in_rd;
  logic        flush;
  logic [3:0]  start;
  logic [31:0] res_cmp, res_add, res_mul, res_div;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_to_int;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] C_CMP = 2'd0;
  localparam logic [1:0] C_ADD = 2'd1;
  localparam logic [1:0] C_MUL = 2'd2;
  localparam logic [1:0] C_DIV = 2'd3;

  fpu_wb_scheduler dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cls    (in_cls),
    .in_rd     (in_rd),
    .flush     (flush),
    .start     (start),
    .res_cmp   (res_cmp),
    .res_add   (res_add),
    .res_mul   (res_mul),
    .res_div   (res_div),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_to_int (wb_to_int),
    .wb_data   (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [4:0] r);
    in_valid = v;
    in_cls   = c;
    in_rd    = r;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [4:0] r,
                        input logic ti, input logic [31:0] d);
    chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".rd"},     {27'd0, wb_rd},     {27'd0, r});
      chk({tag, ".to_int"}, {31'd0, wb_to_int}, {31'd0, ti});
      chk({tag, ".data"},   wb_data,            d);
    end
  endtask

  // Each cycle: inputs set just after a falling edge, outputs checked 1 time unit later.
  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    drive(1'b0, C_CMP, 5'd0);
    res_cmp = 32'h0; res_add = 32'h0; res_mul = 32'h0; res_div = 32'h0;

    // Reset state
    #1;
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst.wb_to_int", {31'd0, wb_to_int}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    nxt; nxt;
    rstn = 1'b1;
    nxt;

    // 1: single ADD rd=5, result in cycle 3, writeback in cycle 4 only
    drive(1'b1, C_ADD, 5'd5); #1;
    chk("add.ready", {31'd0, in_ready}, 32'd1);
    chk("add.start", {28'd0, start}, 32'b0010);
    chk_wb("add.c0", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt;
    drive(1'b0, C_CMP, 5'd0); res_add = 32'h1111_1111; #1;
    chk("add.start_idle", {28'd0, start}, 32'd0);
    chk_wb("add.c1", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt; #1;
    chk_wb("add.c2", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt;
    res_add = 32'h4040_0000; #1;
    chk_wb("add.c3", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt;
    res_add = 32'h2222_2222; #1;
    chk_wb("add.c4", 1'b1, 5'd5, 1'b0, 32'h4040_0000);
    nxt; #1;
    chk_wb("add.c5", 1'b0, 5'd0, 1'b0, 32'd0);
    chk("add.hold_rd", {27'd0, wb_rd}, 32'd5);
    chk("add.hold_data", wb_data, 32'h4040_0000);
    nxt; nxt;

    // 2: collision, ADD rd=1 at c0, CMP rd=2 offered at c2 stalls one cycle
    drive(1'b1, C_ADD, 5'd1); #1;
    chk("col.add_ready", {31'd0, in_ready}, 32'd1);
    nxt;
    drive(1'b0, C_CMP, 5'd0); #1;
    nxt;
    drive(1'b1, C_CMP, 5'd2); #1;
    chk("col.c2_ready", {31'd0, in_ready}, 32'd0);
    chk("col.c2_start", {28'd0, start}, 32'd0);
    nxt;
    res_add = 32'h40A0_0000; #1;
    chk("col.c3_ready", {31'd0, in_ready}, 32'd1);
    chk("col.c3_start", {28'd0, start}, 32'b0001);
    chk_wb("col.c3", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt;
    drive(1'b0, C_CMP, 5'd0); res_add = 32'h3333_3333; res_cmp = 32'h0000_0001; #1;
    chk_wb("col.c4", 1'b1, 5'd1, 1'b0, 32'h40A0_0000);
    nxt;
    res_cmp = 32'h0000_0000; #1;
    chk_wb("col.c5", 1'b1, 5'd2, 1'b1, 32'h0000_0001);
    nxt; #1;
    chk_wb("col.c6", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt; nxt;

    // 3: back-to-back MUL rd=7
    drive(1'b1, C_MUL, 5'd7); #1;
    chk("mul.c0_ready", {31'd0, in_ready}, 32'd1);
    chk("mul.c0_start", {28'd0, start}, 32'b0100);
    nxt; #1;
    chk("mul.c1_ready", {31'd0, in_ready}, 32'd1);
    chk("mul.c1_start", {28'd0, start}, 32'b0100);
    nxt;
    drive(1'b0, C_CMP, 5'd0); res_mul = 32'h3F80_0000; #1;
    chk_wb("mul.c2", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt;
    res_mul = 32'h4000_0000; #1;
    chk_wb("mul.c3", 1'b1, 5'd7, 1'b0, 32'h3F80_0000);
    nxt;
    res_mul = 32'h4444_4444; #1;
    chk_wb("mul.c4", 1'b1, 5'd7, 1'b0, 32'h4000_0000);
    nxt; #1;
    chk_wb("mul.c5", 1'b0, 5'd0, 1'b0, 32'd0);
    nxt; nxt;

    // 4: flush with DIV and ADD in flight; nothing may write back afterwards
    res_add = 32'h5555_5555; res_div = 32'h6666_6666; res_cmp = 32'h7777_7777;
    drive(1'b1, C_DIV, 5'd3); #1;
    nxt;
    drive(1'b1, C_ADD, 5'd4); #1;
    chk("fl.c1_ready", {31'd0, in_ready}, 32'd1);
    nxt;
    drive(1'b1, C_CMP, 5'd9); flush = 1'b1; #1;
    chk("fl.c2_ready", {31'd0, in_ready}, 32'd0);
    chk("fl.c2_start", {28'd0, start}, 32'd0);
    nxt;
    flush = 1'b0; drive(1'b0, C_DIV, 5'd0); #1;
    chk("fl.c3_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      chk_wb("fl.quiet", 1'b0, 5'd0, 1'b0, 32'd0);
      nxt; #1;
    end
    nxt;

    // 5: reset with ADD in flight clears outputs at once and suppresses its writeback
    drive(1'b1, C_ADD, 5'd6); #1;
    nxt;
    drive(1'b0, C_CMP, 5'd0); #1;
    nxt;
    rstn = 1'b0; #1;
    chk("rstm.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstm.wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rstm.wb_to_int", {31'd0, wb_to_int}, 32'd0);
    chk("rstm.wb_data", wb_data, 32'd0);
    nxt;
    rstn = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      chk_wb("rstm.quiet", 1'b0, 5'd0, 1'b0, 32'd0);
      nxt; #1;
    end
    nxt;

    // 6: mixed stream DIV(c0), MUL(c3), CMP offered c4, stalls through c5, accepted c6
    res_add = 32'h0; res_div = 32'h0; res_cmp = 32'h0; res_mul = 32'h0;
    drive(1'b1, C_DIV, 5'd10); #1;
    chk("mix.c0_ready", {31'd0, in_ready}, 32'd1);
    chk("mix.c0_start", {28'd0, start}, 32'b1000);
    nxt;
    drive(1'b0, C_CMP, 5'd0); #1;
    nxt; nxt;
    drive(1'b1, C_MUL, 5'd11); #1;
    chk("mix.c3_ready", {31'd0, in_ready}, 32'd1);
    chk("mix.c3_start", {28'd0, start}, 32'b0100);
    nxt;
    drive(1'b1, C_CMP, 5'd12); #1;
    chk("mix.c4_ready", {31'd0, in_ready}, 32'd0);
    chk("mix.c4_start", {28'd0, start}, 32'd0);
    nxt;
    res_mul = 32'h4100_0000; #1;
    chk("mix.c5_ready", {31'd0, in_ready}, 32'd0);
    nxt;
    res_mul = 32'h8888_8888; res_div = 32'h3E80_0000; #1;
    chk("mix.c6_ready", {31'd0, in_ready}, 32'd1);
    chk("mix.c6_start", {28'd0, start}, 32'b0001);
    chk_wb("mix.c6", 1'b1, 5'd11, 1'b0, 32'h4100_0000);
    nxt;
    drive(1'b0, C_CMP, 5'd0); res_div = 32'h9999_9999; res_cmp = 32'h0000_0000; #1;
    chk_wb("mix.c7", 1'b1, 5'd10, 1'b0, 32'h3E80_0000);
    nxt;
    res_cmp = 32'h0000_0001; #1;
    chk_wb("mix.c8", 1'b1, 5'd12, 1'b1, 32'h0000_0000);
    nxt; #1;
    chk_wb("mix.c9", 1'b0, 5'd0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_wb_scheduler.md
Name: fpu_wb_scheduler

Overview:
- Issue and writeback scheduler for the fixed-latency FPU units: compare (fle/flt/feq), add/sub, mul, div.
- Accepts one FPU op per cycle from decode using a valid/ready handshake and pulses the start of the selected unit.
- Reserves the single shared register-file writeback port for the cycle the unit's result will arrive, stalling issue on a slot collision.
- Muxes the arriving unit result onto one registered writeback bus.

Parameters:
- LAT_CMP, 1, compare unit latency (cycles from start to result)
- LAT_MUL, 2, multiplier latency
- LAT_ADD, 3, adder latency
- LAT_DIV, 6, divider latency
- MAXLAT, 8, reservation depth; every LAT_* must be in 1..MAXLAT-1 (elaboration check)
- RD_W, 5, destination register index width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  op offered
- in_ready  out  1  op accepted this cycle if in_valid
- in_cls  in  2  unit class: 0=CMP, 1=ADD, 2=MUL, 3=DIV
- in_rd  in  RD_W  destination register
- flush  in  1  discard all in-flight ops
- start  out  4  one-hot unit start, indexed by class
- res_cmp, res_add, res_mul, res_div  in  32 each  unit results, valid exactly LAT_* cycles after start
- wb_valid  out  1  writeback this cycle
- wb_rd  out  RD_W  writeback register
- wb_to_int  out  1  1 = integer regfile (CMP results), 0 = float regfile
- wb_data  out  32  writeback value

Behaviour:
- Clock and reset: one clock clk; reset rstn is asynchronous, active-low.
- Reset values: slot vector, tag array, wb_valid, wb_rd, wb_to_int and wb_data are all 0.
- Reservation state: slot[k], k=0..MAXLAT-1. slot[k]=1 means a unit result arrives k cycles after the current cycle. Each entry carries a tag {cls, rd}.
- in_ready = !slot[L(in_cls)] && !flush. This is combinational from in_cls and state; in_valid must not depend on in_ready.
- fire = in_valid && in_ready.
  - start[in_cls] = fire, same cycle, combinational.
  - All other start bits are 0.
- Next state, every cycle:
  - slot'[k] = slot[k+1] for k < MAXLAT-1; slot'[MAXLAT-1] = 0.
  - If fire: slot'[L-1] = 1 and tag'[L-1] = {in_cls, in_rd}.
  - No conflict is possible at L-1: the ready check on slot[L] guarantees it is empty.
- Writeback, registered:
  - If slot[0]: next cycle wb_valid=1, wb_rd=tag[0].rd, wb_to_int=(tag[0].cls==CMP), wb_data=res_<tag[0].cls>.
  - Otherwise wb_valid=0. wb_rd, wb_to_int and wb_data hold their values.
- Latency: an op accepted in cycle t writes back in cycle t+L+1.
- Throughput: 1 op/cycle when latencies do not collide. Ops may complete out of order across classes; register hazards are handled by the core scoreboard, not here.
- flush:
  - Clears slot and tag on the next edge.
  - Forces wb_valid=0 on the next cycle, even if slot[0] was set.
  - in_ready=0 in the flush cycle.
  - Units are not stopped; their late results are ignored because no slot exists for them.
- Reset mid-operation: same effect as flush, asynchronously. No writeback occurs after rstn deassertion until a new op completes.
- Same class back-to-back never collides. Classes with different latencies collide only when the slots coincide; the younger op stalls.

Decomposition:
- Shared package fpu_pkg holds:
  - class encoding constants CLS_CMP/ADD/MUL/DIV;
  - default latency constants;
  - the tag struct {cls, rd}.
- One sub-module: fpu_wb_slot_ring, the MAXLAT-deep shift register of valid bit plus tag. It has a load port (index, tag), a clear input, and exposes slot[] and tag[0].
- The top level holds the ready logic, start decode, result mux and writeback register.

Test Plan:
- ADD, rd=5, accepted cycle 0; res_add=0x40400000 in cycle 3 -> start=0b0010 in cycle 0; wb_valid=1, wb_rd=5, wb_to_int=0, wb_data=0x40400000 in cycle 4 only.
- Collision: ADD rd=1 in cycle 0, CMP rd=2 offered in cycle 2 -> in_ready=0 in cycle 2, accepted cycle 3; wb rd=1 in cycle 4, then rd=2 in cycle 5 with wb_to_int=1 and wb_data=0x00000001.
- Back-to-back MUL rd=7 in cycles 0 and 1 (results 0x3F800000, 0x40000000) -> in_ready stays 1; wb in cycles 3 and 4 with those values.
- Flush in cycle 2 with DIV issued cycle 0 and ADD issued cycle 1 -> no wb_valid at any later cycle; in_ready=0 in cycle 2 and 1 in cycle 3.
- Reset: rstn low in cycle 2 with ADD in flight -> all outputs 0 immediately; after release, no writeback appears until a new op is issued.
- Mixed stream: DIV(c0), MUL(c3), CMP(c4) -> slots resolve to wb cycles 7, 6, 6. The CMP stalls until c5 (wb c7) and collides with DIV again, so it is finally accepted at c6 with wb in c8.
